// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: load-use and branch-operand stalls, data-memory
// freeze, wrong-path flush, and saturating stall/flush statistics counters.
module hazard_stall_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Id_Ex_MemRead,
  input  logic             Id_Ex_Reg_Write,
  input  logic [4:0]       Id_Ex_writereg,
  input  logic             Ex_Mem_MemRead,
  input  logic [4:0]       Ex_Mem_writereg,
  input  logic [6:0]       If_Id_opcode,
  input  logic [4:0]       If_Id_Rs1,
  input  logic [4:0]       If_Id_Rs2,
  input  logic             Branch_Taken,
  input  logic             Dmem_req,
  input  logic             Dmem_ready,
  output logic             Pc_Write,
  output logic             If_Id_Write,
  output logic             Id_Ex_Bubble,
  output logic             If_Id_Flush,
  output logic             Pipe_Freeze,
  output logic [CNT_W-1:0] Stall_Cycles,
  output logic [CNT_W-1:0] Flush_Count
);

  localparam logic [6:0] OpOpImm  = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpBranch = 7'b1100011;

  typedef enum logic {StRun, StStall} state_t;

  state_t           state_q, state_d;
  logic             cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  logic uses_rs2, is_branch, is_jump;
  logic id_ex_hit, ex_mem_hit;
  logic need1, need2;
  logic freeze, stall, flush;

  // rd matches the IF/ID sources; x0 never creates a dependency.
  function automatic logic rd_match(input logic [4:0] rd, input logic [4:0] rs1,
                                    input logic [4:0] rs2, input logic use_rs2);
    return (rd != 5'd0) && ((rd == rs1) || (use_rs2 && (rd == rs2)));
  endfunction

  // Hazard detection: decode IF/ID and compute stall demand, freeze and flush.
  always_comb begin
    uses_rs2   = !(If_Id_opcode inside {OpOpImm, OpLoad, OpJal, OpJalr, OpLui, OpAuipc});
    is_branch  = (If_Id_opcode == OpBranch);
    is_jump    = (If_Id_opcode == OpJal) || (If_Id_opcode == OpJalr);
    id_ex_hit  = rd_match(Id_Ex_writereg, If_Id_Rs1, If_Id_Rs2, uses_rs2);
    ex_mem_hit = rd_match(Ex_Mem_writereg, If_Id_Rs1, If_Id_Rs2, uses_rs2);

    // A branch behind a load must wait for the load to clear MEM as well.
    need2 = is_branch && Id_Ex_MemRead && id_ex_hit;
    need1 = (Id_Ex_MemRead && id_ex_hit) ||
            (is_branch && Id_Ex_Reg_Write && id_ex_hit) ||
            (is_branch && Ex_Mem_MemRead && ex_mem_hit);

    freeze = Dmem_req && !Dmem_ready;
    stall  = !freeze && ((state_q == StStall) || need1 || need2);
    // Branch operands are not valid while stalled, so flushing waits.
    flush  = !freeze && !stall && ((is_branch && Branch_Taken) || is_jump);
  end

  // Next-state logic; a freeze holds both state and cnt.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!freeze) begin
      unique case (state_q)
        StRun: begin
          if (need2) begin
            state_d = StStall;
            cnt_d   = 1'b1;
          end
        end
        StStall: begin
          // cnt is always 1 here; falling back to RUN keeps the FSM recoverable.
          state_d = StRun;
          cnt_d   = 1'b0;
        end
        default: begin
          state_d = StRun;
          cnt_d   = 1'b0;
        end
      endcase
    end
  end

  // Control outputs; reset forces the pipeline into a held, bubbling state.
  always_comb begin
    Pc_Write     = rst_n && !freeze && !stall;
    If_Id_Write  = rst_n && !freeze && !stall;
    Id_Ex_Bubble = !rst_n || stall;
    If_Id_Flush  = rst_n && flush;
    Pipe_Freeze  = rst_n && freeze;
  end

  // FSM state and remaining-count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      cnt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Saturating statistics counters; freeze cycles count as stall cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if ((stall || freeze) && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (flush && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign Stall_Cycles = stall_cnt_q;
  assign Flush_Count  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: per-scenario stimulus tables,
// expected control vectors queued on drive and popped when outputs are sampled.
module tb_hazard_stall_ctrl;

  // Expected {Pc_Write, If_Id_Write, Id_Ex_Bubble, If_Id_Flush, Pipe_Freeze}
  localparam logic [4:0] E_IDL = 5'b11000;
  localparam logic [4:0] E_STL = 5'b00100;
  localparam logic [4:0] E_FLS = 5'b11010;
  localparam logic [4:0] E_FRZ = 5'b00001;
  localparam logic [4:0] E_RST = 5'b00100;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JR  = 7'b1100111;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;

  typedef struct packed {
    logic       mr;
    logic       rw;
    logic [4:0] wr;
    logic       emr;
    logic [4:0] ewr;
    logic [6:0] op;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       bt;
    logic       req;
    logic       rdy;
    logic [4:0] exp;
  } stim_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Id_Ex_MemRead, Id_Ex_Reg_Write, Ex_Mem_MemRead;
  logic [4:0]  Id_Ex_writereg, Ex_Mem_writereg, If_Id_Rs1, If_Id_Rs2;
  logic [6:0]  If_Id_opcode;
  logic        Branch_Taken, Dmem_req, Dmem_ready;
  logic        Pc_Write, If_Id_Write, Id_Ex_Bubble, If_Id_Flush, Pipe_Freeze;
  logic [15:0] Stall_Cycles, Flush_Count;
  logic        pc4, ifw4, bub4, fl4, frz4;
  logic [3:0]  Stall_Cycles4, Flush_Count4;
  logic [4:0]  ctrl, ctrl4;

  int          checks = 0;
  int          errors = 0;
  logic [4:0]  sb[$];
  stim_t       t[$];

  assign ctrl  = {Pc_Write, If_Id_Write, Id_Ex_Bubble, If_Id_Flush, Pipe_Freeze};
  assign ctrl4 = {pc4, ifw4, bub4, fl4, frz4};

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .Id_Ex_MemRead(Id_Ex_MemRead), .Id_Ex_Reg_Write(Id_Ex_Reg_Write),
    .Id_Ex_writereg(Id_Ex_writereg), .Ex_Mem_MemRead(Ex_Mem_MemRead),
    .Ex_Mem_writereg(Ex_Mem_writereg), .If_Id_opcode(If_Id_opcode),
    .If_Id_Rs1(If_Id_Rs1), .If_Id_Rs2(If_Id_Rs2), .Branch_Taken(Branch_Taken),
    .Dmem_req(Dmem_req), .Dmem_ready(Dmem_ready),
    .Pc_Write(Pc_Write), .If_Id_Write(If_Id_Write), .Id_Ex_Bubble(Id_Ex_Bubble),
    .If_Id_Flush(If_Id_Flush), .Pipe_Freeze(Pipe_Freeze),
    .Stall_Cycles(Stall_Cycles), .Flush_Count(Flush_Count)
  );

  hazard_stall_ctrl #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .Id_Ex_MemRead(Id_Ex_MemRead), .Id_Ex_Reg_Write(Id_Ex_Reg_Write),
    .Id_Ex_writereg(Id_Ex_writereg), .Ex_Mem_MemRead(Ex_Mem_MemRead),
    .Ex_Mem_writereg(Ex_Mem_writereg), .If_Id_opcode(If_Id_opcode),
    .If_Id_Rs1(If_Id_Rs1), .If_Id_Rs2(If_Id_Rs2), .Branch_Taken(Branch_Taken),
    .Dmem_req(Dmem_req), .Dmem_ready(Dmem_ready),
    .Pc_Write(pc4), .If_Id_Write(ifw4), .Id_Ex_Bubble(bub4),
    .If_Id_Flush(fl4), .Pipe_Freeze(frz4),
    .Stall_Cycles(Stall_Cycles4), .Flush_Count(Flush_Count4)
  );

  function automatic stim_t mk(input logic mr, input logic rw, input logic [4:0] wr,
                               input logic emr, input logic [4:0] ewr, input logic [6:0] op,
                               input logic [4:0] rs1, input logic [4:0] rs2, input logic bt,
                               input logic req, input logic rdy, input logic [4:0] exp);
    stim_t s;
    s = '{mr: mr, rw: rw, wr: wr, emr: emr, ewr: ewr, op: op, rs1: rs1, rs2: rs2,
          bt: bt, req: req, rdy: rdy, exp: exp};
    return s;
  endfunction

  // Drive one cycle of stimulus and queue its expected control vector.
  task automatic apply(input stim_t s);
    Id_Ex_MemRead   = s.mr;
    Id_Ex_Reg_Write = s.rw;
    Id_Ex_writereg  = s.wr;
    Ex_Mem_MemRead  = s.emr;
    Ex_Mem_writereg = s.ewr;
    If_Id_opcode    = s.op;
    If_Id_Rs1       = s.rs1;
    If_Id_Rs2       = s.rs2;
    Branch_Taken    = s.bt;
    Dmem_req        = s.req;
    Dmem_ready      = s.rdy;
    sb.push_back(s.exp);
  endtask

  task automatic do_reset();
    apply(mk(0, 0, 0, 0, 0, OP_R, 0, 0, 0, 0, 0, E_RST));
    void'(sb.pop_front());
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    apply(mk(1, 1, 5, 0, 0, OP_JAL, 5, 7, 1, 0, 0, E_RST));
    #2;
    checks++;
    if (ctrl !== sb.pop_front()) begin
      errors++;
      $display("FAIL reset_ctrl got=%b exp=%b", ctrl, E_RST);
    end
    checks++;
    if (Stall_Cycles !== 16'd0 || Flush_Count !== 16'd0) begin
      errors++;
      $display("FAIL reset_cnt got=%0d/%0d exp=0/0", Stall_Cycles, Flush_Count);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_load_use();
    logic [4:0] e;
    do_reset();
    t = {};
    t.push_back(mk(1, 1, 5, 0, 0, OP_R, 5, 7, 0, 0, 0, E_STL));
    t.push_back(mk(0, 0, 0, 1, 5, OP_R, 5, 7, 0, 0, 0, E_IDL));
    t.push_back(mk(1, 1, 7, 0, 0, OP_R, 5, 7, 0, 0, 0, E_STL));
    t.push_back(mk(0, 0, 0, 0, 0, OP_R, 5, 7, 0, 0, 0, E_IDL));
    foreach (t[i]) begin
      apply(t[i]);
      #3;
      e = sb.pop_front();
      checks++;
      if (ctrl !== e) begin
        errors++;
        $display("FAIL load_use[%0d] got=%b exp=%b", i, ctrl, e);
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (Stall_Cycles !== 16'd2 || Flush_Count !== 16'd0) begin
      errors++;
      $display("FAIL load_use_cnt got=%0d/%0d exp=2/0", Stall_Cycles, Flush_Count);
    end
  endtask

  task automatic test_branch();
    logic [4:0] e;
    do_reset();
    t = {};
    // beq behind lw: two stalls (second from STALL state alone), then flush
    t.push_back(mk(1, 1, 5, 0, 0, OP_BR, 5, 0, 1, 0, 0, E_STL));
    t.push_back(mk(0, 0, 0, 0, 0, OP_BR, 5, 0, 1, 0, 0, E_STL));
    t.push_back(mk(0, 0, 0, 0, 0, OP_BR, 5, 0, 1, 0, 0, E_FLS));
    t.push_back(mk(0, 0, 0, 0, 0, OP_R, 0, 0, 0, 0, 0, E_IDL));
    // branch behind ALU result, then not taken
    t.push_back(mk(0, 1, 6, 0, 0, OP_BR, 1, 6, 1, 0, 0, E_STL));
    t.push_back(mk(0, 0, 0, 0, 0, OP_BR, 1, 6, 0, 0, 0, E_IDL));
    // branch behind load in MEM, then taken
    t.push_back(mk(0, 0, 0, 1, 9, OP_BR, 9, 3, 1, 0, 0, E_STL));
    t.push_back(mk(0, 0, 0, 0, 0, OP_BR, 9, 3, 1, 0, 0, E_FLS));
    // these two dependencies only matter to branches
    t.push_back(mk(0, 0, 0, 1, 9, OP_R, 9, 3, 0, 0, 0, E_IDL));
    t.push_back(mk(0, 1, 9, 0, 0, OP_R, 3, 9, 0, 0, 0, E_IDL));
    foreach (t[i]) begin
      apply(t[i]);
      #3;
      e = sb.pop_front();
      checks++;
      if (ctrl !== e) begin
        errors++;
        $display("FAIL branch[%0d] got=%b exp=%b", i, ctrl, e);
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (Stall_Cycles !== 16'd4 || Flush_Count !== 16'd2) begin
      errors++;
      $display("FAIL branch_cnt got=%0d/%0d exp=4/2", Stall_Cycles, Flush_Count);
    end
  endtask

  task automatic test_immunity();
    logic [4:0] e;
    do_reset();
    t = {};
    t.push_back(mk(1, 1, 0, 0, 0, OP_R, 0, 0, 0, 0, 0, E_IDL));
    t.push_back(mk(1, 1, 7, 0, 0, OP_IMM, 2, 7, 0, 0, 0, E_IDL));
    t.push_back(mk(1, 1, 7, 0, 0, OP_LD, 2, 7, 0, 0, 0, E_IDL));
    t.push_back(mk(1, 1, 7, 0, 0, OP_LUI, 2, 7, 0, 0, 0, E_IDL));
    t.push_back(mk(1, 1, 7, 0, 0, OP_AUI, 2, 7, 0, 0, 0, E_IDL));
    t.push_back(mk(1, 1, 7, 0, 0, OP_ST, 2, 7, 0, 0, 0, E_STL));
    t.push_back(mk(1, 1, 3, 0, 0, OP_JAL, 0, 3, 0, 0, 0, E_FLS));
    t.push_back(mk(1, 1, 3, 0, 0, OP_JR, 4, 3, 0, 0, 0, E_FLS));
    t.push_back(mk(1, 1, 4, 0, 0, OP_JR, 4, 3, 0, 0, 0, E_STL));
    foreach (t[i]) begin
      apply(t[i]);
      #3;
      e = sb.pop_front();
      checks++;
      if (ctrl !== e) begin
        errors++;
        $display("FAIL immunity[%0d] got=%b exp=%b", i, ctrl, e);
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (Stall_Cycles !== 16'd2 || Flush_Count !== 16'd2) begin
      errors++;
      $display("FAIL immunity_cnt got=%0d/%0d exp=2/2", Stall_Cycles, Flush_Count);
    end
  endtask

  task automatic test_freeze();
    logic [4:0] e;
    do_reset();
    t = {};
    t.push_back(mk(1, 1, 5, 0, 0, OP_BR, 5, 0, 0, 0, 0, E_STL));
    for (int k = 0; k < 3; k++) t.push_back(mk(0, 0, 0, 1, 5, OP_BR, 5, 0, 0, 1, 0, E_FRZ));
    // ready with req: no freeze; STALL state still owed one cycle
    t.push_back(mk(0, 0, 0, 0, 0, OP_BR, 5, 0, 1, 1, 1, E_STL));
    t.push_back(mk(0, 0, 0, 0, 0, OP_R, 0, 0, 0, 0, 0, E_IDL));
    // need is ignored under freeze: no STALL entry, so flush follows directly
    t.push_back(mk(1, 1, 5, 0, 0, OP_BR, 5, 0, 1, 1, 0, E_FRZ));
    t.push_back(mk(0, 0, 0, 0, 0, OP_BR, 5, 0, 1, 0, 0, E_FLS));
    foreach (t[i]) begin
      apply(t[i]);
      #3;
      e = sb.pop_front();
      checks++;
      if (ctrl !== e) begin
        errors++;
        $display("FAIL freeze[%0d] got=%b exp=%b", i, ctrl, e);
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (Stall_Cycles !== 16'd6 || Flush_Count !== 16'd1) begin
      errors++;
      $display("FAIL freeze_cnt got=%0d/%0d exp=6/1", Stall_Cycles, Flush_Count);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] e;
    do_reset();
    t = {};
    t.push_back(mk(1, 1, 5, 0, 0, OP_R, 5, 7, 0, 0, 0, E_STL));
    t.push_back(mk(1, 1, 8, 0, 0, OP_R, 1, 8, 0, 0, 0, E_STL));
    t.push_back(mk(0, 0, 0, 0, 0, OP_JAL, 0, 0, 0, 0, 0, E_FLS));
    t.push_back(mk(0, 0, 0, 0, 0, OP_JAL, 0, 0, 0, 0, 0, E_FLS));
    foreach (t[i]) begin
      apply(t[i]);
      #3;
      e = sb.pop_front();
      checks++;
      if (ctrl !== e) begin
        errors++;
        $display("FAIL back_to_back[%0d] got=%b exp=%b", i, ctrl, e);
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (Stall_Cycles !== 16'd2 || Flush_Count !== 16'd2) begin
      errors++;
      $display("FAIL back_to_back_cnt got=%0d/%0d exp=2/2", Stall_Cycles, Flush_Count);
    end
  endtask

  task automatic test_async_reset();
    logic [4:0] e;
    do_reset();
    apply(mk(1, 1, 5, 0, 0, OP_BR, 5, 0, 0, 0, 0, E_STL));
    #3;
    e = sb.pop_front();
    checks++;
    if (ctrl !== e) begin
      errors++;
      $display("FAIL areset_enter got=%b exp=%b", ctrl, e);
    end
    @(posedge clk);
    #1;
    apply(mk(0, 0, 0, 0, 0, OP_R, 0, 0, 0, 0, 0, E_STL));
    #1;
    e = sb.pop_front();
    checks++;
    if (ctrl !== e) begin
      errors++;
      $display("FAIL areset_in_stall got=%b exp=%b", ctrl, e);
    end
    #1 rst_n = 1'b0;
    sb.push_back(E_RST);
    #1;
    e = sb.pop_front();
    checks++;
    if (ctrl !== e) begin
      errors++;
      $display("FAIL areset_ctrl got=%b exp=%b", ctrl, e);
    end
    checks++;
    if (Stall_Cycles !== 16'd0 || Flush_Count !== 16'd0) begin
      errors++;
      $display("FAIL areset_cnt got=%0d/%0d exp=0/0", Stall_Cycles, Flush_Count);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    apply(mk(0, 0, 0, 0, 0, OP_R, 0, 0, 0, 0, 0, E_IDL));
    #3;
    e = sb.pop_front();
    checks++;
    if (ctrl !== e) begin
      errors++;
      $display("FAIL areset_release got=%b exp=%b", ctrl, e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_saturation();
    logic [4:0] e;
    do_reset();
    for (int k = 0; k < 20; k++) begin
      apply(mk(0, 0, 0, 0, 0, OP_R, 0, 0, 0, 1, 0, E_FRZ));
      #3;
      e = sb.pop_front();
      checks++;
      if (ctrl !== e || ctrl4 !== e) begin
        errors++;
        $display("FAIL saturation[%0d] got=%b/%b exp=%b", k, ctrl, ctrl4, e);
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (Stall_Cycles4 !== 4'd15 || Flush_Count4 !== 4'd0) begin
      errors++;
      $display("FAIL saturation_cnt4 got=%0d/%0d exp=15/0", Stall_Cycles4, Flush_Count4);
    end
    checks++;
    if (Stall_Cycles !== 16'd20) begin
      errors++;
      $display("FAIL saturation_cnt16 got=%0d exp=20", Stall_Cycles);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_immunity();
    test_freeze();
    test_back_to_back();
    test_async_reset();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
